// File: rtl/ss_seq_pkg.sv
// Shared types and constants for the savestate bus sequencer.
// Optional checksum support is enabled with the SS_SEQ_CHECKSUM_EN macro.
package ss_seq_pkg;

   localparam int SS_ADR_W  = 10;
   localparam int SS_DATA_W = 64;
   localparam int SS_MEM_AW = 11;

   typedef enum logic [3:0] {
      IDLE    = 4'd0,
      SV_ADDR = 4'd1,
      SV_WAIT = 4'd2,
      SV_MEM  = 4'd3,
      LD_RST  = 4'd4,
      LD_MEM  = 4'd5,
      LD_WR   = 4'd6,
      LD_HOLD = 4'd7,
      SV_CK   = 4'd8,
      LD_CK   = 4'd9,
      FIN     = 4'd10
   } ss_state_e;

   // One step of the rotate-left-by-one then XOR image checksum.
   function automatic logic [SS_DATA_W-1:0] ss_cks_step(
      input logic [SS_DATA_W-1:0] c,
      input logic [SS_DATA_W-1:0] w
   );
      return {c[SS_DATA_W-2:0], c[SS_DATA_W-1]} ^ w;
   endfunction

endpackage

// File: rtl/ss_checksum.sv
// Rotate-XOR accumulator over the savestate image.
// Only instantiated when SS_SEQ_CHECKSUM_EN is defined.
module ss_checksum
   import ss_seq_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 clr,
   input  logic                 en,
   input  logic [SS_DATA_W-1:0] word,
   output logic [SS_DATA_W-1:0] sum
);

   logic [SS_DATA_W-1:0] sum_d;
   logic [SS_DATA_W-1:0] sum_q;

   // Next accumulator value: clear at operation start, fold in each word.
   always_comb begin
      if (clr) begin
         sum_d = {SS_DATA_W{1'b0}};
      end else if (en) begin
         sum_d = ss_cks_step(sum_q, word);
      end else begin
         sum_d = sum_q;
      end
   end

   // Accumulator register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sum_q <= {SS_DATA_W{1'b0}};
      end else begin
         sum_q <= sum_d;
      end
   end

   assign sum = sum_q;

endmodule

// File: rtl/ss_bus_sequencer.sv
// Savestate bus initiator: walks responder registers to save them to memory,
// or resets responders, replays the image and pulses the load strobe.
// Define SS_SEQ_CHECKSUM_EN to append/verify a rotate-XOR checksum word.
module ss_bus_sequencer
   import ss_seq_pkg::*;
#(
   parameter int NUM_REGS  = 64,
   parameter int READ_LAT  = 1,
   parameter int LOAD_HOLD = 2,
   parameter int MEM_BASE  = 0
)(
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start_save,
   input  logic                 start_load,
   output logic                 busy,
   output logic                 done,
   output logic                 ss_error,
   output logic [SS_DATA_W-1:0] SaveStateBus_Din,
   output logic [SS_ADR_W-1:0]  SaveStateBus_Adr,
   output logic                 SaveStateBus_wren,
   output logic                 SaveStateBus_rst,
   output logic                 SaveStateBus_load,
   input  logic [SS_DATA_W-1:0] SaveStateBus_Dout,
   output logic                 mem_req,
   output logic                 mem_we,
   output logic [SS_MEM_AW-1:0] mem_addr,
   output logic [SS_DATA_W-1:0] mem_wdata,
   input  logic [SS_DATA_W-1:0] mem_rdata,
   input  logic                 mem_ack
);

   localparam logic [SS_ADR_W-1:0]  LAST_IDX  = SS_ADR_W'(NUM_REGS - 1);
   localparam logic [SS_MEM_AW-1:0] BASE_ADDR = SS_MEM_AW'(MEM_BASE);
   localparam logic [SS_MEM_AW-1:0] CK_ADDR   = SS_MEM_AW'(MEM_BASE + NUM_REGS);
   localparam logic [7:0]           WAIT_INIT = 8'(READ_LAT);
   localparam logic [7:0]           HOLD_INIT = 8'(LOAD_HOLD);

   ss_state_e            state_d, state_q;
   logic [SS_ADR_W-1:0]  idx_d, idx_q;
   logic [7:0]           cnt_d, cnt_q;
   logic                 busy_d, busy_q;
   logic                 done_d, done_q;
   logic                 ss_error_d, ss_error_q;
   logic [SS_DATA_W-1:0] din_d, din_q;
   logic [SS_ADR_W-1:0]  adr_d, adr_q;
   logic                 wren_d, wren_q;
   logic                 rst_d, rst_q;
   logic                 load_d, load_q;
   logic                 mem_req_d, mem_req_q;
   logic                 mem_we_d, mem_we_q;
   logic [SS_MEM_AW-1:0] mem_addr_d, mem_addr_q;
   logic [SS_DATA_W-1:0] mem_wdata_d, mem_wdata_q;
   logic [SS_DATA_W-1:0] ck_sum_s;

`ifdef SS_SEQ_CHECKSUM_EN
   localparam bit CK_EN = 1'b1;

   logic                 ck_clr_s;
   logic                 ck_en_s;
   logic [SS_DATA_W-1:0] ck_word_s;

   // Restart at every accepted start; fold in words as they are captured.
   assign ck_clr_s  = (state_q == IDLE) && (start_save || start_load);
   assign ck_en_s   = ((state_q == SV_WAIT) && (cnt_q == 8'd1)) ||
                      ((state_q == LD_MEM) && mem_ack);
   assign ck_word_s = (state_q == SV_WAIT) ? SaveStateBus_Dout : mem_rdata;

   ss_checksum u_checksum (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (ck_clr_s),
      .en      (ck_en_s),
      .word    (ck_word_s),
      .sum     (ck_sum_s)
   );
`else
   localparam bit CK_EN = 1'b0;

   assign ck_sum_s = {SS_DATA_W{1'b0}};
`endif

   // Next-state logic, then every registered output derived from the next state.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      adr_d       = adr_q;
      din_d       = din_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      ss_error_d  = ss_error_q;

      case (state_q)
         IDLE: begin
            if (start_save) begin
               state_d    = SV_ADDR;
               idx_d      = {SS_ADR_W{1'b0}};
               ss_error_d = 1'b0;
            end else if (start_load) begin
               state_d    = LD_RST;
               idx_d      = {SS_ADR_W{1'b0}};
               ss_error_d = 1'b0;
            end else begin
               state_d = IDLE;
            end
         end
         SV_ADDR: begin
            cnt_d   = WAIT_INIT;
            state_d = SV_WAIT;
         end
         SV_WAIT: begin
            cnt_d = cnt_q - 8'd1;
            if (cnt_q <= 8'd1) begin
               mem_wdata_d = SaveStateBus_Dout;
               state_d     = SV_MEM;
            end else begin
               state_d = SV_WAIT;
            end
         end
         SV_MEM: begin
            if (!mem_ack) begin
               state_d = SV_MEM;
            end else if (idx_q == LAST_IDX) begin
               mem_wdata_d = ck_sum_s;
               state_d     = CK_EN ? SV_CK : FIN;
            end else begin
               idx_d   = idx_q + 10'd1;
               state_d = SV_ADDR;
            end
         end
         SV_CK: begin
            if (mem_ack) begin
               state_d = FIN;
            end else begin
               state_d = SV_CK;
            end
         end
         LD_RST: begin
            idx_d   = {SS_ADR_W{1'b0}};
            state_d = LD_MEM;
         end
         LD_MEM: begin
            if (mem_ack) begin
               din_d   = mem_rdata;
               state_d = LD_WR;
            end else begin
               state_d = LD_MEM;
            end
         end
         LD_WR: begin
            if (idx_q == LAST_IDX) begin
               cnt_d   = HOLD_INIT;
               state_d = CK_EN ? LD_CK : LD_HOLD;
            end else begin
               idx_d   = idx_q + 10'd1;
               state_d = LD_MEM;
            end
         end
         LD_CK: begin
            if (!mem_ack) begin
               state_d = LD_CK;
            end else if (mem_rdata != ck_sum_s) begin
               ss_error_d = 1'b1;
               state_d    = FIN;
            end else begin
               cnt_d   = HOLD_INIT;
               state_d = LD_HOLD;
            end
         end
         LD_HOLD: begin
            cnt_d = cnt_q - 8'd1;
            if (cnt_q <= 8'd1) begin
               state_d = FIN;
            end else begin
               state_d = LD_HOLD;
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if ((state_d == SV_ADDR) || (state_d == LD_WR)) begin
         adr_d = idx_d;
      end else begin
         adr_d = adr_q;
      end

      if ((state_d == SV_MEM) || (state_d == LD_MEM)) begin
         mem_addr_d = BASE_ADDR + {1'b0, idx_d};
      end else if ((state_d == SV_CK) || (state_d == LD_CK)) begin
         mem_addr_d = CK_ADDR;
      end else begin
         mem_addr_d = mem_addr_q;
      end

      busy_d    = (state_d != IDLE);
      done_d    = (state_d == FIN);
      rst_d     = (state_d == LD_RST);
      wren_d    = (state_d == LD_WR);
      load_d    = (state_d == LD_HOLD);
      mem_req_d = (state_d == SV_MEM) || (state_d == LD_MEM) ||
                  (state_d == SV_CK)  || (state_d == LD_CK);
      mem_we_d  = (state_d == SV_MEM) || (state_d == SV_CK);
   end

   // Sequencer state and registered outputs; reset aborts any operation.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         idx_q       <= {SS_ADR_W{1'b0}};
         cnt_q       <= 8'd0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         ss_error_q  <= 1'b0;
         din_q       <= {SS_DATA_W{1'b0}};
         adr_q       <= {SS_ADR_W{1'b0}};
         wren_q      <= 1'b0;
         rst_q       <= 1'b0;
         load_q      <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= {SS_MEM_AW{1'b0}};
         mem_wdata_q <= {SS_DATA_W{1'b0}};
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         ss_error_q  <= ss_error_d;
         din_q       <= din_d;
         adr_q       <= adr_d;
         wren_q      <= wren_d;
         rst_q       <= rst_d;
         load_q      <= load_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign busy              = busy_q;
   assign done              = done_q;
   assign ss_error          = ss_error_q;
   assign SaveStateBus_Din  = din_q;
   assign SaveStateBus_Adr  = adr_q;
   assign SaveStateBus_wren = wren_q;
   assign SaveStateBus_rst  = rst_q;
   assign SaveStateBus_load = load_q;
   assign mem_req           = mem_req_q;
   assign mem_we            = mem_we_q;
   assign mem_addr          = mem_addr_q;
   assign mem_wdata         = mem_wdata_q;

endmodule

// File: tb/tb_ss_bus_sequencer.sv
// Directed bench for ss_bus_sequencer (NUM_REGS=4, READ_LAT=1, LOAD_HOLD=2).
// A second instance with MEM_BASE=2046 exercises memory address wrap.
module tb_ss_bus_sequencer;

`ifdef SS_SEQ_CHECKSUM_EN
   localparam int CKX = 1;
`else
   localparam int CKX = 0;
`endif

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start_save = 1'b0;
   logic        start_load = 1'b0;
   logic        busy, done, ss_error;
   logic [63:0] ss_din;
   logic [9:0]  ss_adr;
   logic        ss_wren, ss_rst, ss_load;
   logic [63:0] ss_dout = 64'd0;
   logic        mem_req, mem_we;
   logic [10:0] mem_addr;
   logic [63:0] mem_wdata;
   logic [63:0] mem_rdata = 64'd0;
   logic        mem_ack;
   logic        model_ack = 1'b0;
   logic        inj_ack = 1'b0;
   int          req_age = 0;
   logic [63:0] resp_base = 64'd0;
   logic [63:0] img [0:7];

   // second instance (address wrap)
   logic        b_start_save = 1'b0;
   logic        b_start_load;
   logic        b_busy, b_done, b_ss_error;
   logic [63:0] b_din;
   logic [9:0]  b_adr;
   logic        b_wren, b_rst, b_load;
   logic [63:0] b_dout;
   logic        b_mem_req, b_mem_we;
   logic [10:0] b_mem_addr;
   logic [63:0] b_mem_wdata;
   logic [63:0] b_mem_rdata;
   logic        b_mem_ack = 1'b0;
   int          b_req_age = 0;

   assign b_start_load = 1'b0;
   assign b_dout       = 64'd0;
   assign b_mem_rdata  = 64'd0;
   assign mem_ack      = model_ack | inj_ack;

   int checks = 0;
   int errors = 0;

   // monitor state
   int cyc = 0;
   int busy_cnt, done_cnt, rst_cnt, wren_cnt, load_cnt, req_cyc, viol;
   int first_rst, first_wren, last_wren, first_load;
   int b_done_cnt = 0;
   logic prev_done = 1'b0;
   logic [9:0]  wr_adr [$];
   logic [63:0] wr_din [$];
   logic [10:0] mlog_addr [$];
   logic [63:0] mlog_data [$];
   logic [10:0] b_addrs [$];

   ss_bus_sequencer #(.NUM_REGS(4), .READ_LAT(1), .LOAD_HOLD(2), .MEM_BASE(0)) dut (
      .clk(clk), .reset_n(reset_n), .start_save(start_save), .start_load(start_load),
      .busy(busy), .done(done), .ss_error(ss_error),
      .SaveStateBus_Din(ss_din), .SaveStateBus_Adr(ss_adr), .SaveStateBus_wren(ss_wren),
      .SaveStateBus_rst(ss_rst), .SaveStateBus_load(ss_load), .SaveStateBus_Dout(ss_dout),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   ss_bus_sequencer #(.NUM_REGS(4), .READ_LAT(1), .LOAD_HOLD(2), .MEM_BASE(2046)) dut_b (
      .clk(clk), .reset_n(reset_n), .start_save(b_start_save), .start_load(b_start_load),
      .busy(b_busy), .done(b_done), .ss_error(b_ss_error),
      .SaveStateBus_Din(b_din), .SaveStateBus_Adr(b_adr), .SaveStateBus_wren(b_wren),
      .SaveStateBus_rst(b_rst), .SaveStateBus_load(b_load), .SaveStateBus_Dout(b_dout),
      .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
      .mem_rdata(b_mem_rdata), .mem_ack(b_mem_ack)
   );

   always #5 clk = ~clk;

   // responder model: one-cycle registered read of base + index
   always @(posedge clk) ss_dout <= resp_base + {54'd0, ss_adr};

   // memory model A: ack two cycles after request, reads from img
   always @(posedge clk) begin
      model_ack <= 1'b0;
      if (mem_req && !model_ack) begin
         if (req_age == 1) begin
            model_ack <= 1'b1;
            req_age   <= 0;
            if (!mem_we) mem_rdata <= img[mem_addr[2:0]];
         end else begin
            req_age <= req_age + 1;
         end
      end else begin
         req_age <= 0;
      end
   end

   // memory model B: same ack timing
   always @(posedge clk) begin
      b_mem_ack <= 1'b0;
      if (b_mem_req && !b_mem_ack) begin
         if (b_req_age == 1) begin
            b_mem_ack <= 1'b1;
            b_req_age <= 0;
         end else begin
            b_req_age <= b_req_age + 1;
         end
      end else begin
         b_req_age <= 0;
      end
   end

   // observe outputs at the falling edge
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (busy) busy_cnt = busy_cnt + 1;
      if (done) done_cnt = done_cnt + 1;
      if (ss_rst) begin
         rst_cnt = rst_cnt + 1;
         if (first_rst < 0) first_rst = cyc;
      end
      if (ss_wren) begin
         wren_cnt = wren_cnt + 1;
         if (first_wren < 0) first_wren = cyc;
         last_wren = cyc;
         wr_adr.push_back(ss_adr);
         wr_din.push_back(ss_din);
      end
      if (ss_load) begin
         load_cnt = load_cnt + 1;
         if (first_load < 0) first_load = cyc;
      end
      if (mem_req) req_cyc = req_cyc + 1;
      if (mem_req && mem_ack && mem_we) begin
         mlog_addr.push_back(mem_addr);
         mlog_data.push_back(mem_wdata);
      end
      if ((int'(ss_wren) + int'(ss_rst) + int'(ss_load)) > 1) viol = viol + 1;
      if (!busy && (ss_wren || ss_rst || ss_load || mem_req)) viol = viol + 1;
      if (done && !busy) viol = viol + 1;
      if (prev_done && (busy || done)) viol = viol + 1;
      prev_done = done;
      if (b_done) b_done_cnt = b_done_cnt + 1;
      if (b_mem_req && b_mem_ack) b_addrs.push_back(b_mem_addr);
   end

   function automatic logic [63:0] cks4(input logic [3:0][63:0] w);
      logic [63:0] c;
      c = 64'd0;
      for (int i = 0; i < 4; i++) c = {c[62:0], c[63]} ^ w[i];
      return c;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clear_mon();
      busy_cnt = 0; done_cnt = 0; rst_cnt = 0; wren_cnt = 0; load_cnt = 0;
      req_cyc = 0; viol = 0;
      first_rst = -1; first_wren = -1; last_wren = -1; first_load = -1;
      wr_adr.delete(); wr_din.delete(); mlog_addr.delete(); mlog_data.delete();
   endtask

   task automatic tick(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic start_txn(input logic s, input logic l);
      tick(1);
      start_save = s;
      start_load = l;
      tick(1);
      start_save = 1'b0;
      start_load = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n;
      n = 0;
      while (done_cnt == 0 && n < budget) begin
         tick(1);
         n++;
      end
      if (done_cnt == 0) begin
         checks = checks + 1;
         errors = errors + 1;
         $display("FAIL done_timeout: got no done within %0d cycles", budget);
      end
      tick(3);
   endtask

   typedef struct {
      bit              is_load;
      bit              both;
      logic [63:0]     base;
      logic [3:0][63:0] words;
      int              exp_lat;
      int              exp_wr;
      int              exp_wren;
      int              exp_rst;
      int              exp_load;
   } vec_t;

   vec_t vecs [5];

   initial begin
      logic [63:0] q64;
      logic [3:0][63:0] w;

      vecs[0] = '{1'b0, 1'b0, 64'hA0, {64'hA3, 64'hA2, 64'hA1, 64'hA0}, 21, 4, 0, 0, 0};
      vecs[1] = '{1'b1, 1'b0, 64'h0, {64'h44, 64'h33, 64'h22, 64'h11}, 20, 0, 4, 1, 2};
      vecs[2] = '{1'b0, 1'b1, 64'h1000, {64'h1003, 64'h1002, 64'h1001, 64'h1000}, 21, 4, 0, 0, 0};
      vecs[3] = '{1'b1, 1'b0, 64'h0, {64'h5A5A_5A5A_A5A5_A5A5, 64'h8000_0000_0000_0001,
                                      64'h0, 64'hFFFF_FFFF_FFFF_FFFF}, 20, 0, 4, 1, 2};
      vecs[4] = '{1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE,
                  {64'h1, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE}, 21, 4, 0, 0, 0};
      for (int i = 0; i < 8; i++) img[i] = 64'd0;

      // reset state
      clear_mon();
      tick(3);
      chk("rst_busy_done_err", {61'd0, busy, done, ss_error}, 64'd0);
      chk("rst_strobes", {61'd0, ss_wren, ss_rst, ss_load}, 64'd0);
      chk("rst_mem_req_we", {62'd0, mem_req, mem_we}, 64'd0);
      chk("rst_adr_addr", {43'd0, ss_adr, mem_addr}, 64'd0);
      chk("rst_din", ss_din, 64'd0);
      chk("rst_wdata", mem_wdata, 64'd0);
      reset_n = 1'b1;
      tick(2);

      // table-driven transactions
      for (int v = 0; v < 5; v++) begin
         resp_base = vecs[v].base;
         for (int i = 0; i < 4; i++) img[i] = vecs[v].words[i];
         img[4] = cks4(vecs[v].words);
         clear_mon();
         start_txn(!vecs[v].is_load || vecs[v].both, vecs[v].is_load || vecs[v].both);
         wait_done(300);
         chk($sformatf("v%0d_latency", v), 64'(busy_cnt), 64'(vecs[v].exp_lat + CKX * 3));
         chk($sformatf("v%0d_done_cnt", v), 64'(done_cnt), 64'd1);
         chk($sformatf("v%0d_rst_cnt", v), 64'(rst_cnt), 64'(vecs[v].exp_rst));
         chk($sformatf("v%0d_wren_cnt", v), 64'(wren_cnt), 64'(vecs[v].exp_wren));
         chk($sformatf("v%0d_load_cycles", v), 64'(load_cnt), 64'(vecs[v].exp_load));
         chk($sformatf("v%0d_mem_writes", v), 64'(mlog_addr.size()),
             64'(vecs[v].exp_wr + ((vecs[v].exp_wr > 0) ? CKX : 0)));
         chk($sformatf("v%0d_ss_error", v), {63'd0, ss_error}, 64'd0);
         chk($sformatf("v%0d_protocol", v), 64'(viol), 64'd0);
         if (!vecs[v].is_load) begin
            for (int i = 0; i < 4; i++) begin
               q64 = (i < mlog_data.size()) ? mlog_data[i] : 64'hDEAD_BEEF_DEAD_BEEF;
               chk($sformatf("v%0d_word%0d", v, i), q64, vecs[v].words[i]);
               q64 = (i < mlog_addr.size()) ? {53'd0, mlog_addr[i]} : 64'hFFFF;
               chk($sformatf("v%0d_waddr%0d", v, i), q64, 64'(i));
            end
`ifdef SS_SEQ_CHECKSUM_EN
            q64 = (mlog_data.size() > 4) ? mlog_data[4] : 64'hDEAD_BEEF_DEAD_BEEF;
            chk($sformatf("v%0d_cks_word", v), q64, cks4(vecs[v].words));
`endif
         end else begin
            for (int i = 0; i < 4; i++) begin
               q64 = (i < wr_adr.size()) ? {54'd0, wr_adr[i]} : 64'hFFFF;
               chk($sformatf("v%0d_wren_adr%0d", v, i), q64, 64'(i));
               q64 = (i < wr_din.size()) ? wr_din[i] : 64'hDEAD_BEEF_DEAD_BEEF;
               chk($sformatf("v%0d_wren_din%0d", v, i), q64, vecs[v].words[i]);
            end
            chk($sformatf("v%0d_rst_before_wren", v), {63'd0, (first_rst >= 0) && (first_rst < first_wren)}, 64'd1);
            chk($sformatf("v%0d_load_after_wren", v), 64'(first_load - last_wren), 64'(1 + CKX * 3));
         end
      end

      // arbitration: both starts together, then start_load while busy
      resp_base = 64'h200;
      clear_mon();
      start_txn(1'b1, 1'b1);
      tick(4);
      start_load = 1'b1;
      tick(1);
      start_load = 1'b0;
      wait_done(300);
      tick(10);
      chk("arb_no_rst", 64'(rst_cnt), 64'd0);
      chk("arb_no_wren", 64'(wren_cnt), 64'd0);
      chk("arb_save_writes", 64'(mlog_addr.size()), 64'(4 + CKX));
      chk("arb_single_done", 64'(done_cnt), 64'd1);
      chk("arb_idle_after", {63'd0, busy}, 64'd0);

      // reset in the middle of a load, with a stray ack afterwards
      w = {64'h4444, 64'h3333, 64'h2222, 64'h1111};
      for (int i = 0; i < 4; i++) img[i] = w[i];
      img[4] = cks4(w);
      clear_mon();
      start_txn(1'b0, 1'b1);
      begin
         int n;
         n = 0;
         while (wren_cnt < 2 && n < 100) begin
            tick(1);
            n++;
         end
      end
      chk("mid_wren_reached", 64'(wren_cnt), 64'd2);
      reset_n = 1'b0;
      tick(1);
      chk("mid_busy_done_err", {61'd0, busy, done, ss_error}, 64'd0);
      chk("mid_strobes", {61'd0, ss_wren, ss_rst, ss_load}, 64'd0);
      chk("mid_mem_req_we", {62'd0, mem_req, mem_we}, 64'd0);
      chk("mid_adr_addr", {43'd0, ss_adr, mem_addr}, 64'd0);
      chk("mid_din", ss_din, 64'd0);
      chk("mid_no_load_before", 64'(load_cnt), 64'd0);
      reset_n = 1'b1;
      inj_ack = 1'b1;
      clear_mon();
      tick(1);
      inj_ack = 1'b0;
      tick(8);
      chk("mid_ack_no_busy", 64'(busy_cnt), 64'd0);
      chk("mid_ack_no_activity", 64'(wren_cnt + rst_cnt + load_cnt + req_cyc), 64'd0);

`ifdef SS_SEQ_CHECKSUM_EN
      // corrupted image, then intact image
      w = {64'hDD, 64'hCC, 64'hBB, 64'hAA};
      for (int i = 0; i < 4; i++) img[i] = w[i];
      img[4] = cks4(w);
      img[2] = img[2] ^ 64'h1;
      clear_mon();
      start_txn(1'b0, 1'b1);
      wait_done(300);
      chk("ck_bad_error", {63'd0, ss_error}, 64'd1);
      chk("ck_bad_no_load", 64'(load_cnt), 64'd0);
      chk("ck_bad_done", 64'(done_cnt), 64'd1);
      img[2] = w[2];
      clear_mon();
      start_txn(1'b0, 1'b1);
      wait_done(300);
      chk("ck_good_error", {63'd0, ss_error}, 64'd0);
      chk("ck_good_load", 64'(load_cnt), 64'd2);
`endif

      // memory address wrap on the second instance
      b_addrs.delete();
      tick(1);
      b_start_save = 1'b1;
      tick(1);
      b_start_save = 1'b0;
      begin
         int n;
         n = 0;
         while (b_done_cnt == 0 && n < 300) begin
            tick(1);
            n++;
         end
      end
      chk("wrap_done", 64'(b_done_cnt), 64'd1);
      chk("wrap_count", 64'(b_addrs.size()), 64'(4 + CKX));
      w = {64'd1, 64'd0, 64'd2047, 64'd2046};
      for (int i = 0; i < 4; i++) begin
         q64 = (i < b_addrs.size()) ? {53'd0, b_addrs[i]} : 64'hFFFF;
         chk($sformatf("wrap_addr%0d", i), q64, w[i]);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
